// File: rtl/d_responder.sv
// SD-bus data-line responder: receives one 1024-nibble block with per-lane CRC-16 and answers with a
// CRC-status token and a busy period, or sends one block from RAM. Define D_RESPONDER_CRC_CHECK_EN to enable the received-CRC check.
module d_responder (
  input  logic       iclk,
  input  logic       irst,
  input  logic [3:0] idata_sd,
  output logic [3:0] odata_sd,
  output logic [3:0] ooe,
  input  logic       istart_rcv,
  input  logic       istart_send,
  output logic [9:0] oaddr,
  output logic [3:0] owdata,
  output logic       owrite_en,
  input  logic [3:0] irdata,
  input  logic       iprog_done,
  output logic       ocrc_fail,
  output logic       odone
);

  typedef enum logic [3:0] {
    IDLE, WAIT_START, RCV_DATA, RCV_CRC, RCV_END, GAP, TOKEN, BUSY,
    SEND_START, SEND_DATA, SEND_CRC, SEND_END
  } state_t;

  state_t           state_r;
  logic [9:0]       cnt_r;
  logic [9:0]       addr_r;
  logic [3:0][15:0] crc_r;
  logic             err_r;
  logic [3:0]       tok_r;
  logic [3:0]       data_r;
  logic [3:0]       oe_r;
  logic             wen_r;
  logic             fail_r;
  logic             done_r;

  logic [3:0]       crc_in_s;
  logic [3:0][15:0] crc_next_s;
  logic [3:0]       crc_msb_s;
  logic [3:0]       crc_nmsb_s;
  logic             crc_mis_s;
  logic             end_bad_s;

  // One serial step of x^16+x^12+x^5+1, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Per-lane CRC next value and the MSB nibbles used for CRC transmit/compare.
  always_comb begin
    if (state_r == SEND_DATA) begin
      crc_in_s = irdata;
    end else begin
      crc_in_s = idata_sd;
    end
    for (int i = 0; i < 4; i++) begin
      crc_next_s[i] = crc16_step(crc_r[i], crc_in_s[i]);
      crc_msb_s[i]  = crc_r[i][15];
      crc_nmsb_s[i] = crc_next_s[i][15];
    end
  end

`ifdef D_RESPONDER_CRC_CHECK_EN
  assign crc_mis_s = (idata_sd != crc_msb_s);
`else
  assign crc_mis_s = 1'b0;
`endif
  assign end_bad_s = (idata_sd != 4'hF);

  // Data nibbles come straight from RAM so that oaddr leads the bus by exactly one cycle.
  assign odata_sd  = (state_r == SEND_DATA) ? irdata : data_r;
  assign ooe       = oe_r;
  assign oaddr     = addr_r;
  assign owdata    = idata_sd;
  assign owrite_en = wen_r;
  assign ocrc_fail = fail_r;
  assign odone     = done_r;

  // Main FSM with registered line/strobe outputs.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_r <= IDLE;
      cnt_r   <= 10'd0;
      addr_r  <= 10'd0;
      crc_r   <= 64'h0;
      err_r   <= 1'b0;
      tok_r   <= 4'h0;
      data_r  <= 4'hF;
      oe_r    <= 4'h0;
      wen_r   <= 1'b0;
      fail_r  <= 1'b0;
      done_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (istart_rcv) begin
            state_r <= WAIT_START;
            fail_r  <= 1'b0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
          end else if (istart_send) begin
            state_r <= SEND_START;
            oe_r    <= 4'hF;
            data_r  <= 4'h0;
            addr_r  <= 10'd0;
            cnt_r   <= 10'd0;
            crc_r   <= 64'h0;
            done_r  <= 1'b0;
          end
        end
        WAIT_START: begin
          if (idata_sd == 4'h0) begin
            state_r <= RCV_DATA;
            cnt_r   <= 10'd0;
            addr_r  <= 10'd0;
            crc_r   <= 64'h0;
            wen_r   <= 1'b1;
          end
        end
        RCV_DATA: begin
          crc_r  <= crc_next_s;
          cnt_r  <= cnt_r + 10'd1;
          addr_r <= addr_r + 10'd1;
          if (cnt_r == 10'd1023) begin
            state_r <= RCV_CRC;
            wen_r   <= 1'b0;
          end
        end
        RCV_CRC: begin
          for (int i = 0; i < 4; i++) begin
            crc_r[i] <= {crc_r[i][14:0], 1'b0};
          end
          if (crc_mis_s) begin
            err_r <= 1'b1;
          end
          cnt_r <= cnt_r + 10'd1;
          if (cnt_r == 10'd15) begin
            state_r <= RCV_END;
            cnt_r   <= 10'd0;
          end
        end
        RCV_END: begin
          err_r   <= err_r | end_bad_s;
          fail_r  <= err_r | end_bad_s;
          state_r <= GAP;
          cnt_r   <= 10'd0;
        end
        GAP: begin
          cnt_r <= cnt_r + 10'd1;
          if (cnt_r == 10'd1) begin
            state_r <= TOKEN;
            cnt_r   <= 10'd0;
            oe_r    <= 4'b0001;
            data_r  <= 4'b1110;
            tok_r   <= {(err_r ? 3'b101 : 3'b010), 1'b1};
          end
        end
        TOKEN: begin
          // tok_r holds the status bits and closing 1 still to be shifted out on D0.
          cnt_r  <= cnt_r + 10'd1;
          data_r <= {3'b111, tok_r[3]};
          tok_r  <= {tok_r[2:0], 1'b0};
          if (cnt_r == 10'd4) begin
            cnt_r <= 10'd0;
            if (err_r) begin
              state_r <= IDLE;
              oe_r    <= 4'h0;
              data_r  <= 4'hF;
              done_r  <= 1'b1;
            end else begin
              state_r <= BUSY;
              data_r  <= 4'b1110;
            end
          end
        end
        BUSY: begin
          if (iprog_done) begin
            state_r <= IDLE;
            oe_r    <= 4'h0;
            data_r  <= 4'hF;
            done_r  <= 1'b1;
          end
        end
        SEND_START: begin
          state_r <= SEND_DATA;
          addr_r  <= addr_r + 10'd1;
          cnt_r   <= 10'd0;
        end
        SEND_DATA: begin
          crc_r  <= crc_next_s;
          cnt_r  <= cnt_r + 10'd1;
          addr_r <= addr_r + 10'd1;
          if (cnt_r == 10'd1023) begin
            state_r <= SEND_CRC;
            data_r  <= crc_nmsb_s;
            for (int i = 0; i < 4; i++) begin
              crc_r[i] <= {crc_next_s[i][14:0], 1'b0};
            end
          end
        end
        SEND_CRC: begin
          data_r <= crc_msb_s;
          for (int i = 0; i < 4; i++) begin
            crc_r[i] <= {crc_r[i][14:0], 1'b0};
          end
          cnt_r <= cnt_r + 10'd1;
          if (cnt_r == 10'd15) begin
            state_r <= SEND_END;
            data_r  <= 4'hF;
            cnt_r   <= 10'd0;
          end
        end
        SEND_END: begin
          state_r <= IDLE;
          oe_r    <= 4'h0;
          data_r  <= 4'hF;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          oe_r    <= 4'h0;
          data_r  <= 4'hF;
          wen_r   <= 1'b0;
          done_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_responder.sv
// Directed bench for d_responder: receive good/bad blocks, send from a RAM model, reset mid-send, start collision.
module tb_d_responder;

  logic       iclk = 1'b0;
  logic       irst;
  logic [3:0] idata_sd;
  logic [3:0] odata_sd;
  logic [3:0] ooe;
  logic       istart_rcv;
  logic       istart_send;
  logic [9:0] oaddr;
  logic [3:0] owdata;
  logic       owrite_en;
  logic [3:0] irdata = 4'h0;
  logic       iprog_done;
  logic       ocrc_fail;
  logic       odone;

  always #5 iclk = ~iclk;

  d_responder dut (
    .iclk(iclk), .irst(irst), .idata_sd(idata_sd), .odata_sd(odata_sd), .ooe(ooe),
    .istart_rcv(istart_rcv), .istart_send(istart_send), .oaddr(oaddr), .owdata(owdata),
    .owrite_en(owrite_en), .irdata(irdata), .iprog_done(iprog_done),
    .ocrc_fail(ocrc_fail), .odone(odone)
  );

`ifdef D_RESPONDER_CRC_CHECK_EN
  localparam bit CRC_CHK = 1'b1;
`else
  localparam bit CRC_CHK = 1'b0;
`endif

  logic [3:0] ram [1024];
  always @(posedge iclk) irdata <= ram[oaddr];

  int wr_cnt = 0;
  int drv_cnt = 0;
  always @(posedge iclk) begin
    if (owrite_en) wr_cnt <= wr_cnt + 1;
    if (ooe == 4'hF) drv_cnt <= drv_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    return (c[15] ^ b) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
  endfunction

  // Block 0x00..0xFF repeated, high nibble of each byte first.
  function automatic logic [3:0] blk_nib(input int k);
    logic [7:0] bv;
    bv = 8'((k / 2) % 256);
    return (k % 2 == 0) ? bv[7:4] : bv[3:0];
  endfunction

  task automatic rcv_block(input int corrupt_j, input logic [3:0] end_nib, input bit exp_err);
    logic [15:0] mcrc [4];
    logic [3:0]  n;
    logic [4:0]  tok;
    int          wr_base;
    for (int i = 0; i < 4; i++) mcrc[i] = 16'h0;
    @(negedge iclk); istart_rcv = 1'b1; idata_sd = 4'hF;
    @(negedge iclk); istart_rcv = 1'b0;
    chk("wait_ooe", 32'(ooe), 32'h0);
    chk("wait_odone", 32'(odone), 32'h0);
    chk("wait_fail_clr", 32'(ocrc_fail), 32'h0);
    @(negedge iclk); idata_sd = 4'h0;
    wr_base = wr_cnt;
    for (int k = 0; k < 1024; k++) begin
      @(negedge iclk);
      n = blk_nib(k);
      idata_sd = n;
      for (int i = 0; i < 4; i++) mcrc[i] = crc_upd(mcrc[i], n[i]);
      #1;
      chk("rcv_wen", 32'(owrite_en), 32'h1);
      chk("rcv_addr", 32'(oaddr), 32'(k));
      chk("rcv_wdata", 32'(owdata), 32'(n));
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge iclk);
      for (int i = 0; i < 4; i++) n[i] = mcrc[i][15 - j];
      if (j == corrupt_j) n[2] = ~n[2];
      idata_sd = n;
      #1;
      chk("rcv_crc_nowen", 32'(owrite_en), 32'h0);
    end
    @(negedge iclk); idata_sd = end_nib;
    @(negedge iclk); idata_sd = 4'hF;
    chk("rcv_writes", 32'(wr_cnt - wr_base), 32'd1024);
    chk("crc_fail", 32'(ocrc_fail), 32'(exp_err));
    chk("gap0_ooe", 32'(ooe), 32'h0);
    @(negedge iclk);
    chk("gap1_ooe", 32'(ooe), 32'h0);
    tok = exp_err ? 5'b01011 : 5'b00101;
    for (int t = 0; t < 5; t++) begin
      @(negedge iclk);
      chk("tok_ooe", 32'(ooe), 32'h1);
      chk("tok_bit", 32'(odata_sd[0]), 32'(tok[4 - t]));
    end
    if (!exp_err) begin
      for (int b = 0; b < 3; b++) begin
        @(negedge iclk);
        chk("busy_ooe", 32'(ooe), 32'h1);
        chk("busy_d0", 32'(odata_sd[0]), 32'h0);
        chk("busy_odone", 32'(odone), 32'h0);
      end
      iprog_done = 1'b1;
      @(negedge iclk); iprog_done = 1'b0;
    end else begin
      @(negedge iclk);
    end
    chk("end_odone", 32'(odone), 32'h1);
    chk("end_ooe", 32'(ooe), 32'h0);
    chk("end_odata", 32'(odata_sd), 32'hF);
  endtask

  task automatic send_block(input int rst_at);
    logic [15:0] mcrc [4];
    logic [3:0]  n;
    int          drv_base;
    for (int i = 0; i < 4; i++) mcrc[i] = 16'h0;
    drv_base = drv_cnt;
    @(negedge iclk); istart_send = 1'b1;
    @(negedge iclk); istart_send = 1'b0;
    chk("ss_ooe", 32'(ooe), 32'hF);
    chk("ss_data", 32'(odata_sd), 32'h0);
    chk("ss_addr", 32'(oaddr), 32'h0);
    chk("ss_odone", 32'(odone), 32'h0);
    for (int k = 0; k < 1024; k++) begin
      @(negedge iclk);
      n = ram[k];
      for (int i = 0; i < 4; i++) mcrc[i] = crc_upd(mcrc[i], n[i]);
      chk("sd_data", 32'(odata_sd), 32'(n));
      chk("sd_ooe", 32'(ooe), 32'hF);
      chk("sd_addr", 32'(oaddr), 32'((k + 1) % 1024));
      if (k == rst_at) begin
        irst = 1'b1;
        @(negedge iclk); irst = 1'b0;
        chk("rst_ooe", 32'(ooe), 32'h0);
        chk("rst_odone", 32'(odone), 32'h1);
        chk("rst_odata", 32'(odata_sd), 32'hF);
        chk("rst_addr", 32'(oaddr), 32'h0);
        return;
      end
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge iclk);
      for (int i = 0; i < 4; i++) n[i] = mcrc[i][15 - j];
      chk("sc_data", 32'(odata_sd), 32'(n));
      chk("sc_ooe", 32'(ooe), 32'hF);
    end
    @(negedge iclk);
    chk("se_data", 32'(odata_sd), 32'hF);
    chk("se_ooe", 32'(ooe), 32'hF);
    @(negedge iclk);
    chk("sidle_ooe", 32'(ooe), 32'h0);
    chk("sidle_odone", 32'(odone), 32'h1);
    chk("sidle_odata", 32'(odata_sd), 32'hF);
    chk("send_cycles", 32'(drv_cnt - drv_base), 32'd1042);
  endtask

  initial begin
    logic [9:0] kk;
    irst = 1'b1; idata_sd = 4'hF; istart_rcv = 1'b0; istart_send = 1'b0; iprog_done = 1'b0;
    for (int k = 0; k < 1024; k++) ram[k] = 4'hA;
    repeat (2) @(negedge iclk);
    chk("rst_odone0", 32'(odone), 32'h1);
    chk("rst_ooe0", 32'(ooe), 32'h0);
    chk("rst_odata0", 32'(odata_sd), 32'hF);
    chk("rst_wen0", 32'(owrite_en), 32'h0);
    chk("rst_addr0", 32'(oaddr), 32'h0);
    chk("rst_fail0", 32'(ocrc_fail), 32'h0);
    irst = 1'b0;

    rcv_block(-1, 4'hF, 1'b0);
    rcv_block(5, 4'hF, CRC_CHK);
    rcv_block(-1, 4'h7, 1'b1);

    send_block(-1);
    send_block(500);
    for (int k = 0; k < 1024; k++) begin
      kk = 10'(k);
      ram[k] = kk[3:0] ^ kk[9:6];
    end
    send_block(-1);

    @(negedge iclk); istart_rcv = 1'b1; istart_send = 1'b1;
    @(negedge iclk); istart_rcv = 1'b0; istart_send = 1'b0;
    chk("both_ooe", 32'(ooe), 32'h0);
    chk("both_odone", 32'(odone), 32'h0);
    @(negedge iclk); istart_send = 1'b1;
    @(negedge iclk); istart_send = 1'b0;
    chk("ign_send_ooe", 32'(ooe), 32'h0);
    @(negedge iclk);
    chk("ign_send_ooe2", 32'(ooe), 32'h0);
    chk("ign_send_wen", 32'(owrite_en), 32'h0);
    irst = 1'b1;
    @(negedge iclk); irst = 1'b0;
    chk("final_odone", 32'(odone), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
